// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg: shared widths, sequencer FSM encoding and the layer
// address map used by the conv-step address decoder and RAM read sequencer.
package cnn_mem_pkg;

  localparam int ADDR_W_DEF = 15;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  // Layer windows in pixel / weight RAM (end addresses exclusive)
  localparam logic [14:0] L1_PIX_BASE = 15'd0;
  localparam logic [14:0] L1_PIX_END  = 15'd1600;
  localparam logic [14:0] L1_WGT_BASE = 15'd0;
  localparam logic [14:0] L1_WGT_END  = 15'd228;
  localparam logic [14:0] L2_PIX_BASE = 15'd1600;
  localparam logic [14:0] L2_WGT_BASE = 15'd228;

endpackage

// File: rtl/seq_out_fifo.sv
// seq_out_fifo: synchronous FIFO for the sequencer output stream.
// Ports: push_i/din_i write, pop_i/dout_o read head, count_o occupancy.
module seq_out_fifo #(
  parameter  int W     = 17,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop;

  assign do_pop = pop_i && (cnt_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + AW'(1);
      if (do_pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wp_q] <= din_i;
  end

  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ram_read_sequencer.sv
// ram_read_sequencer: walks [firstaddr,lastaddr) in pixel or weight RAM
// and streams returned words out over valid/ready with last/done/busy.
module ram_read_sequencer
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              re_RAM_p,
  input  logic              re_RAM_w,
  input  logic [ADDR_W-1:0] firstaddr,
  input  logic [ADDR_W-1:0] lastaddr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en_p,
  output logic              rd_en_w,
  input  logic [DATA_W-1:0] rd_data_p,
  input  logic [DATA_W-1:0] rd_data_w,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              empty_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              src_w_q, src_w_d;
  logic              err_q, err_d;
  logic [CW-1:0]     outs_q, outs_d;
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] lst_q;
  logic [CW-1:0]     fcnt;
  logic [DATA_W:0]   fdin;
  logic [DATA_W:0]   fdout;
  logic              accept;
  logic              issue;
  logic              push;
  logic              pop;
  logic              drained;
  logic              is_empty;

  assign accept   = (state_q == S_IDLE) && start
                  && (re_RAM_p || re_RAM_w);
  assign is_empty = lastaddr <= firstaddr;

  // Reads in flight plus buffered words may never exceed FIFO space
  assign issue = (state_q == S_ISSUE)
               && ((fcnt + outs_q) < CW'(FIFO_DEPTH));

  assign push = vld_q[RD_LAT-1];
  assign pop  = out_valid && out_ready;

  // Nothing remains after this edge: no reads in flight and the
  // FIFO is empty or is handing over its final entry now
  assign drained = (outs_q == '0)
                 && ((fcnt == '0) || ((fcnt == CW'(1)) && pop));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    src_w_d = src_w_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          ptr_d   = firstaddr;
          cnt_d   = lastaddr - firstaddr;
          src_w_d = !re_RAM_p;
          err_d   = is_empty;
          // An empty window still passes through DRAIN so that
          // done follows the same exit path as a real window
          state_d = is_empty ? S_DRAIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          ptr_d = ptr_q + ADDR_W'(1);
          cnt_d = cnt_q - ADDR_W'(1);
          if (cnt_q == ADDR_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drained) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign outs_d = outs_q + CW'(issue) - CW'(push);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      src_w_q <= 1'b0;
      err_q   <= 1'b0;
      outs_q  <= '0;
      vld_q   <= '0;
      lst_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      src_w_q <= src_w_d;
      err_q   <= err_d;
      outs_q  <= outs_d;
      vld_q   <= RD_LAT'({vld_q, issue});
      lst_q   <= RD_LAT'({lst_q, issue && (cnt_q == ADDR_W'(1))});
    end
  end

  assign fdin = {lst_q[RD_LAT-1], src_w_q ? rd_data_w : rd_data_p};

  seq_out_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (fdin),
    .pop_i   (pop),
    .dout_o  (fdout),
    .count_o (fcnt)
  );

  assign rd_addr   = issue ? ptr_q : '0;
  assign rd_en_p   = issue && !src_w_q;
  assign rd_en_w   = issue && src_w_q;
  assign out_valid = fcnt != '0;
  assign out_data  = out_valid ? fdout[DATA_W-1:0] : '0;
  assign out_last  = out_valid && fdout[DATA_W];
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_DONE;
  assign empty_err = err_q;

endmodule
